// File: rtl/qdec_filter.sv
// -----------------------------------------------------------------------------
// qdec_filter
//
// Quadrature decoder for one incremental encoder channel pair. The A/B levels
// arrive already synchronized to clk. Each channel goes through a glitch filter
// first. The filtered Gray-code transitions are then decoded into:
//   - a wrapping two's-complement position count,
//   - a direction flag,
//   - a one-cycle step strobe,
//   - a sticky illegal-transition flag.
//
// Optional feature (macro QDEC_INDEX_EN):
//   Adds an index channel Z, filtered like A/B. A filtered rising edge of Z
//   zeroes the position and pulses idx for one cycle.
//
// Parameters
//   FILT_LEN   consecutive differing samples needed before the filtered level
//              follows the raw level (1..255; 1 = plain register stage)
//   CNT_WIDTH  width of the position counter
//
// Ports
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   a_in     synchronized encoder channel A
//   b_in     synchronized encoder channel B
//   z_in     synchronized index channel (QDEC_INDEX_EN only)
//   clr      level-sensitive synchronous clear of pos
//   err_clr  level-sensitive clear of err
//   pos      signed position count (wraps modulo 2^CNT_WIDTH)
//   dir      direction of last counted step, 1 = forward
//   step     one-cycle pulse per counted step
//   err      sticky illegal-transition (both channels changed) flag
//   idx      one-cycle pulse on filtered Z rising edge (QDEC_INDEX_EN only)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module qdec_filter #(
    parameter int FILT_LEN  = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_in,
    input  logic                 b_in,
`ifdef QDEC_INDEX_EN
    input  logic                 z_in,
    output logic                 idx,
`endif
    input  logic                 clr,
    input  logic                 err_clr,
    output logic [CNT_WIDTH-1:0] pos,
    output logic                 dir,
    output logic                 step,
    output logic                 err
);

    // Channel 0 = A, channel 1 = B, channel 2 = Z (index build only).
`ifdef QDEC_INDEX_EN
    localparam int NCH = 3;
`else
    localparam int NCH = 2;
`endif

    // Counter value at which the next differing sample is accepted.
    localparam logic [7:0] FILT_LAST = 8'(FILT_LEN - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t               state_q, state_d;
    logic [NCH-1:0]       raw;
    logic [NCH-1:0]       filt_q, filt_d;
    logic [NCH-1:0]       prev_q, prev_d;
    logic [NCH-1:0][7:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] pos_q, pos_d;
    logic                 dir_q, dir_d;
    logic                 step_q, step_d;
    logic                 err_q, err_d;
`ifdef QDEC_INDEX_EN
    logic                 idx_q, idx_d;
`endif

    logic                 run;
    logic [1:0]           g_cur, g_prv, g_delta;
    logic                 fwd, rev, illegal, index_hit;

`ifdef QDEC_INDEX_EN
    assign raw = {z_in, b_in, a_in};
`else
    assign raw = {b_in, a_in};
`endif

    // Position of an {A,B} pair along the forward cycle 00->01->11->10.
    function automatic logic [1:0] gray_pos(input logic a, input logic b);
        logic [1:0] p;
        case ({a, b})
            2'b00:   p = 2'd0;
            2'b01:   p = 2'd1;
            2'b11:   p = 2'd2;
            default: p = 2'd3;
        endcase
        return p;
    endfunction

    // Decode compares the current filtered pair with the pair one cycle
    // earlier. The modulo-4 distance along the cycle gives the direction:
    // 1 = forward, 3 = reverse, 2 = both bits changed (illegal).
    assign run     = (state_q == ST_RUN);
    assign g_cur   = gray_pos(filt_q[0], filt_q[1]);
    assign g_prv   = gray_pos(prev_q[0], prev_q[1]);
    assign g_delta = g_cur - g_prv;
    assign fwd     = run && (g_delta == 2'd1);
    assign rev     = run && (g_delta == 2'd3);
    assign illegal = run && (g_delta == 2'd2);

`ifdef QDEC_INDEX_EN
    assign index_hit = run && filt_q[2] && !prev_q[2];
`else
    assign index_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        filt_d  = filt_q;
        prev_d  = prev_q;
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        err_d   = err_q;
`ifdef QDEC_INDEX_EN
        idx_d   = 1'b0;
`endif

        case (state_q)
            // Take the encoder's resting levels as-is so a non-00 rest
            // position is not decoded as a step or illegal jump.
            ST_INIT: begin
                filt_d  = raw;
                prev_d  = raw;
                cnt_d   = '0;
                state_d = ST_RUN;
            end

            ST_RUN: begin
                for (int i = 0; i < NCH; i++) begin
                    if (raw[i] == filt_q[i]) begin
                        cnt_d[i] = 8'd0;
                    end else if (cnt_q[i] == FILT_LAST) begin
                        filt_d[i] = raw[i];
                        cnt_d[i]  = 8'd0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 8'd1;
                    end
                end

                prev_d = filt_q;

                if (fwd) begin
                    pos_d  = pos_q + CNT_WIDTH'(1);
                    dir_d  = 1'b1;
                    step_d = 1'b1;
                end else if (rev) begin
                    pos_d  = pos_q - CNT_WIDTH'(1);
                    dir_d  = 1'b0;
                    step_d = 1'b1;
                end

`ifdef QDEC_INDEX_EN
                idx_d = index_hit;
`endif
            end

            default: state_d = ST_INIT;
        endcase

        // Clearing wins over a simultaneous count; step/dir still report it.
        if (clr || index_hit) begin
            pos_d = '0;
        end

        // A fresh illegal transition keeps err set even while err_clr is high.
        if (illegal) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            filt_q  <= '0;
            prev_q  <= '0;
            cnt_q   <= '0;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef QDEC_INDEX_EN
            idx_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            filt_q  <= filt_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            err_q   <= err_d;
`ifdef QDEC_INDEX_EN
            idx_q   <= idx_d;
`endif
        end
    end

    assign pos  = pos_q;
    assign dir  = dir_q;
    assign step = step_q;
    assign err  = err_q;
`ifdef QDEC_INDEX_EN
    assign idx  = idx_q;
`endif

endmodule

// File: tb/tb_qdec_filter.sv
// -----------------------------------------------------------------------------
// tb_qdec_filter
//
// Self-checking bench for qdec_filter. Main instance uses FILT_LEN=4 and is
// compared every cycle against a behavioural model: the filter accepts a raw
// level once the last FILT_LEN samples all differ from the filtered level, and
// decode is the modulo-4 distance along the Gray cycle. A second instance with
// FILT_LEN=1 is driven one step per cycle to reach the 0x7FFF -> 0x8000 wrap.
// Honours QDEC_INDEX_EN when defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_qdec_filter;

    localparam int FL = 4;
    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, a_in, b_in, clr, err_clr;
    logic [CW-1:0] pos;
    logic          dir, step, err;
    logic          rst_w, a_w, b_w, clr_w, err_clr_w;
    logic [CW-1:0] pos_w;
    logic          dir_w, step_w, err_w;
`ifdef QDEC_INDEX_EN
    logic          z_in, idx, z_w, idx_w;
`endif

    qdec_filter #(.FILT_LEN(FL), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in),
`ifdef QDEC_INDEX_EN
        .z_in(z_in), .idx(idx),
`endif
        .clr(clr), .err_clr(err_clr),
        .pos(pos), .dir(dir), .step(step), .err(err)
    );

    qdec_filter #(.FILT_LEN(1), .CNT_WIDTH(CW)) dut_w (
        .clk(clk), .rst(rst_w), .a_in(a_w), .b_in(b_w),
`ifdef QDEC_INDEX_EN
        .z_in(z_w), .idx(idx_w),
`endif
        .clr(clr_w), .err_clr(err_clr_w),
        .pos(pos_w), .dir(dir_w), .step(step_w), .err(err_w)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int step_seen, idx_seen, stepw_seen;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit            m_init;
    logic [2:0]    m_f, m_prev;
    logic [FL-1:0] m_hist [3];
    int            m_nval [3];
    logic [CW-1:0] m_pos;
    bit            m_dir, m_step, m_err, m_idx;

    function automatic int gidx(input logic a, input logic b);
        if (!a && !b) return 0;
        if (!a &&  b) return 1;
        if ( a &&  b) return 2;
        return 3;
    endfunction

    function automatic logic [1:0] gstate(input int i);
        logic [1:0] r;
        case (i % 4)
            0:       r = 2'b00;
            1:       r = 2'b01;
            2:       r = 2'b11;
            default: r = 2'b10;
        endcase
        return r;
    endfunction

    task automatic model_step();
        logic [2:0] smp;
        int  d;
        bit  zr;
`ifdef QDEC_INDEX_EN
        smp = {z_in, b_in, a_in};
`else
        smp = {1'b0, b_in, a_in};
`endif
        if (rst) begin
            m_init = 1; m_f = '0; m_prev = '0; m_pos = '0;
            m_dir = 0; m_step = 0; m_err = 0; m_idx = 0;
            for (int c = 0; c < 3; c++) m_nval[c] = 0;
        end else if (m_init) begin
            m_init = 0; m_f = smp; m_prev = smp;
            for (int c = 0; c < 3; c++) m_nval[c] = 0;
            m_step = 0; m_idx = 0;
            if (clr) m_pos = '0;
            if (err_clr) m_err = 0;
        end else begin
            d = (gidx(m_f[0], m_f[1]) - gidx(m_prev[0], m_prev[1]) + 4) % 4;
            m_step = 0;
            m_idx  = 0;
            if (d == 1) begin m_pos = m_pos + 1'b1; m_dir = 1; m_step = 1; end
            if (d == 3) begin m_pos = m_pos - 1'b1; m_dir = 0; m_step = 1; end
`ifdef QDEC_INDEX_EN
            zr = m_f[2] && !m_prev[2];
`else
            zr = 0;
`endif
            m_idx = zr;
            if (clr || zr) m_pos = '0;
            if (d == 2) m_err = 1;
            else if (err_clr) m_err = 0;
            m_prev = m_f;
            for (int c = 0; c < 3; c++) begin
                m_hist[c] = {m_hist[c][FL-2:0], smp[c]};
                if (m_nval[c] < FL) m_nval[c]++;
                if (m_nval[c] >= FL && m_hist[c] == {FL{~m_f[c]}}) m_f[c] = smp[c];
            end
        end
    endtask

    // One clock: advance model with the inputs the DUT samples, then compare.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("pos",  pos,  m_pos);
        check_eq("dir",  dir,  m_dir);
        check_eq("step", step, m_step);
        check_eq("err",  err,  m_err);
`ifdef QDEC_INDEX_EN
        check_eq("idx",  idx,  m_idx);
        if (idx) idx_seen++;
`endif
        if (step)   step_seen++;
        if (step_w) stepw_seen++;
    endtask

    task automatic hold(input int n);
        repeat (n) tick();
    endtask

    task automatic go_fwd();
        logic [1:0] ab;
        ab = gstate(gidx(a_in, b_in) + 1);
        {a_in, b_in} = ab;
    endtask

    task automatic go_rev();
        logic [1:0] ab;
        ab = gstate(gidx(a_in, b_in) + 3);
        {a_in, b_in} = ab;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] ab;
        int s0, hl;
        rst = 1; a_in = 1; b_in = 1; clr = 0; err_clr = 0;
        rst_w = 1; a_w = 0; b_w = 0; clr_w = 0; err_clr_w = 0;
`ifdef QDEC_INDEX_EN
        z_in = 0; z_w = 0;
`endif
        step_seen = 0; idx_seen = 0; stepw_seen = 0;

        // Reset while resting at 11: no spurious step or error.
        hold(3);
        rst = 0;
        step_seen = 0;
        hold(20);
        check_eq("rst11_pos", pos, 0);
        check_eq("rst11_err", err, 0);
        check_eq("rst11_steps", step_seen, 0);

        // Re-reset at 00, then forward cycle with latency check per step.
        rst = 1; a_in = 0; b_in = 0;
        hold(2);
        rst = 0;
        hold(5);
        step_seen = 0;
        for (int i = 0; i < 4; i++) begin
            go_fwd();
            hold(FL);
            check_eq("fwd_lat_early", step, 0);
            hold(1);
            check_eq("fwd_lat_step", step, 1);
            hold(10 - FL - 1);
        end
        check_eq("fwd_pos", pos, 4);
        check_eq("fwd_dir", dir, 1);
        check_eq("fwd_steps", step_seen, 4);

        // Clear, then reverse through zero.
        clr = 1; hold(1); clr = 0; hold(2);
        check_eq("clr_pos", pos, 0);
        go_rev(); hold(10);
        check_eq("rev_pos", pos, 16'hFFFF);
        check_eq("rev_dir", dir, 0);
        for (int i = 0; i < 3; i++) begin
            go_rev(); hold(10);
        end
        check_eq("rev4_pos", pos, 16'hFFFC);

        // 3-cycle glitch on A is rejected.
        s0 = step_seen;
        a_in = 1; hold(3); a_in = 0; hold(10);
        check_eq("glitch_pos", pos, 16'hFFFC);
        check_eq("glitch_steps", step_seen, s0);
        check_eq("glitch_err", err, 0);

        // 4-cycle pulse on B: one forward then one reverse step.
        b_in = 1; hold(4); b_in = 0; hold(2);
        check_eq("pulse_fwd_pos", pos, 16'hFFFD);
        check_eq("pulse_fwd_dir", dir, 1);
        hold(10);
        check_eq("pulse_rev_pos", pos, 16'hFFFC);
        check_eq("pulse_rev_dir", dir, 0);
        check_eq("pulse_steps", step_seen, s0 + 2);

        // Illegal 00->11, then err_clr coinciding with 11->00.
        a_in = 1; b_in = 1; hold(10);
        check_eq("ill_err", err, 1);
        check_eq("ill_pos", pos, 16'hFFFC);
        a_in = 0; b_in = 0; hold(FL);
        err_clr = 1; hold(1); err_clr = 0;
        check_eq("ill_errclr_race", err, 1);
        hold(3);
        err_clr = 1; hold(1); err_clr = 0;
        check_eq("errclr_alone", err, 0);
        check_eq("ill2_pos", pos, 16'hFFFC);

        // clr coinciding with a forward step.
        b_in = 1; hold(FL);
        clr = 1; hold(1); clr = 0;
        check_eq("clrstep_pos", pos, 0);
        check_eq("clrstep_step", step, 1);
        check_eq("clrstep_dir", dir, 1);
        hold(5);

`ifdef QDEC_INDEX_EN
        // Index rising edge at pos=37.
        clr = 1; hold(1); clr = 0;
        for (int i = 0; i < 37; i++) begin
            go_fwd(); hold(FL + 1);
        end
        hold(3);
        check_eq("idx_pre_pos", pos, 37);
        idx_seen = 0;
        z_in = 1; hold(FL);
        check_eq("idx_early", idx, 0);
        hold(1);
        check_eq("idx_pos", pos, 0);
        check_eq("idx_pulse", idx, 1);
        z_in = 0; hold(12);
        check_eq("idx_count", idx_seen, 1);
`endif

        // Randomized walk: legal steps, illegal jumps, short glitches,
        // sprinkled clr/err_clr/rst, model-checked every cycle.
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 15))
                0, 1, 2, 3, 4, 5, 6, 7, 8: go_fwd();
                9, 10, 11, 12:             go_rev();
                13: begin ab = {a_in, b_in}; {a_in, b_in} = ~ab; end
                default: begin
                    a_in = ~a_in; hold($urandom_range(1, FL - 1)); a_in = ~a_in;
                end
            endcase
`ifdef QDEC_INDEX_EN
            if ($urandom_range(0, 7) == 0) z_in = ~z_in;
`endif
            hl = $urandom_range(1, 10);
            for (int k = 0; k < hl; k++) begin
                clr     = ($urandom_range(0, 39) == 0);
                err_clr = ($urandom_range(0, 11) == 0);
                rst     = ($urandom_range(0, 299) == 0);
                tick();
                clr = 0; err_clr = 0; rst = 0;
            end
        end

        // Wrap 0x7FFF -> 0x8000 on the FILT_LEN=1 instance, one step per cycle.
        hold(2);
        rst_w = 0;
        hold(3);
        stepw_seen = 0;
        for (int i = 0; i < 32767; i++) begin
            ab = gstate(gidx(a_w, b_w) + 1);
            {a_w, b_w} = ab;
            tick();
        end
        hold(3);
        check_eq("wrap_pre_pos", pos_w, 16'h7FFF);
        check_eq("wrap_b2b_steps", stepw_seen, 32767);
        ab = gstate(gidx(a_w, b_w) + 1);
        {a_w, b_w} = ab;
        hold(3);
        check_eq("wrap_pos", pos_w, 16'h8000);
        check_eq("wrap_dir", dir_w, 1);
        check_eq("wrap_err", err_w, 0);
`ifdef QDEC_INDEX_EN
        check_eq("wrap_idx", idx_w, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
